// File: rtl/plot_pkg.sv
// Shared widths, frame geometry, FIFO entry type and FSM states for the plot receiver.
// The pixel address function uses shifts so that no multiplier is needed.
package plot_pkg;
   localparam int XSZ       = 8;
   localparam int YSZ       = 7;
   localparam int COLSZ     = 3;
   localparam int X_MAX     = 160;
   localparam int Y_MAX     = 120;
   localparam int FRAME_PIX = 19200;
   localparam int ADDR_W    = 15;

   typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

   typedef struct packed {
      logic [XSZ-1:0]   x;
      logic [YSZ-1:0]   y;
      logic [COLSZ-1:0] colour;
   } plot_t;

   // y*160 + x == (y<<7) + (y<<5) + x
   function automatic logic [ADDR_W-1:0] pix_addr(input logic [YSZ-1:0] y,
                                                  input logic [XSZ-1:0] x);
      logic [ADDR_W-1:0] yw;
      yw = ADDR_W'(y);
      return (yw << 7) + (yw << 5) + ADDR_W'(x);
   endfunction
endpackage

// File: rtl/plot_receiver_frame_ram.sv
// Single-port synchronous frame buffer, read-first, one-cycle read latency.
// Contents are deliberately never reset.
module frame_ram
   import plot_pkg::*;
#(
   parameter int DATA_W = plot_pkg::COLSZ,
   parameter int DEPTH  = plot_pkg::FRAME_PIX,
   parameter int AW     = plot_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic [AW-1:0]     addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/plot_receiver.sv
// Plot stream receiver: clips, buffers plots in a small FIFO, writes them into
// the frame buffer, and serves reads and whole-frame clears on the same RAM port.
module plot_receiver
   import plot_pkg::*;
#(
   parameter int XSZ        = plot_pkg::XSZ,
   parameter int YSZ        = plot_pkg::YSZ,
   parameter int COLSZ      = plot_pkg::COLSZ,
   parameter int FIFO_DEPTH = 8,
   parameter int X_MAX      = plot_pkg::X_MAX,
   parameter int Y_MAX      = plot_pkg::Y_MAX,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [XSZ-1:0]   x,
   input  logic [YSZ-1:0]   y,
   input  logic [COLSZ-1:0] colour,
   input  logic             plotEn,
   output logic             plot_ready,
   input  logic             rd_req,
   input  logic [XSZ-1:0]   rd_x,
   input  logic [YSZ-1:0]   rd_y,
   output logic             rd_valid,
   output logic [COLSZ-1:0] rd_data,
   input  logic             clear_req,
   input  logic [COLSZ-1:0] clear_col,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] clip_count
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   state_t            state;
   plot_t             fifo_mem [FIFO_DEPTH];
   plot_t             head;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_next;
   logic [ADDR_W-1:0] clr_addr, ram_addr;
   logic [COLSZ-1:0]  clr_col, ram_wdata, ram_q;
   logic              ready_r, rd_valid_r, rd_oor_r;
   logic              in_range, push, pop, drop;
   logic              fifo_empty, fifo_full, rd_accept, rd_oor, ram_we;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_range   = (32'(x) < 32'(X_MAX)) && (32'(y) < 32'(Y_MAX));
   assign rd_oor     = !((32'(rd_x) < 32'(X_MAX)) && (32'(rd_y) < 32'(Y_MAX)));
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign head       = fifo_mem[rd_ptr];

   // A read or a clear request takes the RAM port, so the pop waits that cycle.
   assign pop        = (state == WRITE) && !fifo_empty && !rd_req && !clear_req;
   assign push       = plotEn && in_range && (!fifo_full || pop);
   assign drop       = plotEn && in_range && !push;
   assign count_next = count + CW'(push) - CW'(pop);
   assign rd_accept  = rd_req && (state != CLEAR);

   always_comb begin
      ram_addr  = pix_addr(head.y, head.x);
      ram_wdata = head.colour;
      ram_we    = pop;
      if (state == CLEAR) begin
         ram_addr  = clr_addr;
         ram_wdata = clr_col;
         ram_we    = 1'b1;
      end else if (rd_accept) begin
         ram_addr  = rd_oor ? '0 : pix_addr(rd_y, rd_x);
         ram_we    = 1'b0;
      end
   end

   frame_ram #(.DATA_W(COLSZ), .DEPTH(FRAME_PIX), .AW(ADDR_W)) u_ram (
      .clk   (clk),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{x: x, y: y, colour: colour};
      if (state != CLEAR && clear_req) clr_col <= clear_col;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         clr_addr   <= '0;
         ready_r    <= 1'b1;
         rd_valid_r <= 1'b0;
         rd_oor_r   <= 1'b0;
         overflow   <= 1'b0;
         wr_count   <= '0;
         clip_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) begin
            rd_ptr   <= ptr_inc(rd_ptr);
            wr_count <= sat_inc(wr_count);
         end
         count      <= count_next;
         ready_r    <= (count_next != CW'(FIFO_DEPTH));
         rd_valid_r <= rd_accept;
         rd_oor_r   <= rd_oor;
         if (drop) overflow <= 1'b1;
         if (plotEn && !in_range) clip_count <= sat_inc(clip_count);

         case (state)
            IDLE: begin
               if (clear_req) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
               end else if (!fifo_empty) begin
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (clear_req) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
               end else if (count_next == '0) begin
                  state <= IDLE;
               end
            end
            CLEAR: begin
               if (clr_addr == ADDR_W'(FRAME_PIX - 1)) begin
                  state    <= IDLE;
                  clr_addr <= '0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign plot_ready = ready_r;
   assign rd_valid   = rd_valid_r;
   assign rd_data    = (rd_valid_r && !rd_oor_r) ? ram_q : '0;
   assign busy       = (state == CLEAR) || !fifo_empty;
endmodule

// File: tb/tb_plot_receiver.sv
// Bench for plot_receiver: read responses are checked by a scoreboard monitor,
// status outputs are checked directly after each directed scenario.
module tb_plot_receiver;
   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  x, rd_x;
   logic [6:0]  y, rd_y;
   logic [2:0]  colour, clear_col, rd_data;
   logic        plotEn, plot_ready, rd_req, rd_valid, clear_req, busy, overflow;
   logic [15:0] wr_count, clip_count;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [2:0]  exp_q[$];
   logic [2:0]  e_val;
   int          n;

   always #5 clk = ~clk;

   plot_receiver dut (
      .clk        (clk),
      .resetn     (resetn),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plotEn     (plotEn),
      .plot_ready (plot_ready),
      .rd_req     (rd_req),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .clear_req  (clear_req),
      .clear_col  (clear_col),
      .busy       (busy),
      .overflow   (overflow),
      .wr_count   (wr_count),
      .clip_count (clip_count)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Monitor: every read response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resetn && rd_valid) begin
         if (exp_q.size() == 0) begin
            check("rd_unexpected", 1, 0);
         end else begin
            e_val = exp_q.pop_front();
            check("rd_data", int'(rd_data), int'(e_val));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
      x = px; y = py; colour = pc; plotEn = 1'b1;
      step();
      plotEn = 1'b0;
   endtask

   task automatic read(input logic [7:0] rx, input logic [6:0] ry, input logic [2:0] exp);
      rd_x = rx; rd_y = ry; rd_req = 1'b1;
      exp_q.push_back(exp);
      step();
      rd_req = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (busy && k < 200) begin
         step();
         k++;
      end
      check("drain_busy", int'(busy), 0);
   endtask

   task automatic do_reset();
      step();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
      step();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      resetn = 1'b0; x = '0; y = '0; colour = '0; plotEn = 1'b0;
      rd_req = 1'b0; rd_x = '0; rd_y = '0; clear_req = 1'b0; clear_col = '0;
      repeat (3) step();
      resetn = 1'b1;
      step();

      check("rst_plot_ready", int'(plot_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_rd_valid", int'(rd_valid), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_wr_count", int'(wr_count), 0);
      check("rst_clip_count", int'(clip_count), 0);

      // Scenario 1: basic writes and read-back, out-of-range read, read-over-write
      plot(8'd3, 7'd2, 3'd5);
      plot(8'd159, 7'd119, 3'd1);
      drain();
      read(8'd3, 7'd2, 3'd5);
      read(8'd159, 7'd119, 3'd1);
      read(8'd200, 7'd5, 3'd0);
      check("s1_wr_count", int'(wr_count), 2);
      plot(8'd3, 7'd2, 3'd7);
      step();
      read(8'd3, 7'd2, 3'd5);
      drain();
      read(8'd3, 7'd2, 3'd7);
      check("s1_wr_count_after", int'(wr_count), 3);

      // Scenario 2: clipped plots
      do_reset();
      plot(8'd160, 7'd0, 3'd3);
      check("s2_busy_a", int'(busy), 0);
      plot(8'd0, 7'd120, 3'd4);
      check("s2_busy_b", int'(busy), 0);
      step();
      check("s2_busy_c", int'(busy), 0);
      check("s2_clip_count", int'(clip_count), 2);
      check("s2_wr_count", int'(wr_count), 0);
      check("s2_overflow", int'(overflow), 0);

      // Scenario 3: pops stalled by a held read, FIFO fills and overflows
      do_reset();
      rd_req = 1'b1; rd_x = 8'd200; rd_y = 7'd0;
      for (int i = 0; i < 12; i++) begin
         x = 8'(i); y = 7'd1; colour = 3'((i * 3 + 1) & 7); plotEn = 1'b1;
         exp_q.push_back(3'd0);
         step();
         if (i == 6) check("s3_ready_7th", int'(plot_ready), 1);
         if (i == 7) check("s3_ready_8th", int'(plot_ready), 0);
      end
      plotEn = 1'b0;
      rd_req = 1'b0;
      check("s3_overflow", int'(overflow), 1);
      check("s3_busy", int'(busy), 1);
      drain();
      check("s3_wr_count", int'(wr_count), 8);
      check("s3_overflow_sticky", int'(overflow), 1);
      read(8'd0, 7'd1, 3'd1);
      read(8'd4, 7'd1, 3'd5);
      read(8'd7, 7'd1, 3'd6);

      // Scenario 4: full-frame clear, reads ignored while clearing
      do_reset();
      clear_col = 3'd2; clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      n = 0;
      while (busy && n < 20000) begin
         n++;
         if (n == 100) begin
            rd_x = 8'd80; rd_y = 7'd60; rd_req = 1'b1;
         end
         if (n == 101) begin
            check("s4_rd_valid_in_clear", int'(rd_valid), 0);
            rd_req = 1'b0;
         end
         step();
      end
      check("s4_busy_cycles", n, 19200);
      read(8'd80, 7'd60, 3'd2);
      read(8'd3, 7'd2, 3'd2);
      check("s4_wr_count", int'(wr_count), 0);

      // Scenario 5: reset in the middle of a clear
      do_reset();
      plot(8'd10, 7'd10, 3'd3);
      drain();
      check("s5_wr_count_pre", int'(wr_count), 1);
      clear_col = 3'd6; clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (5000) @(posedge clk);
      #2;
      check("s5_busy_pre", int'(busy), 1);
      resetn = 1'b0;
      #1;
      check("s5_rst_plot_ready", int'(plot_ready), 1);
      check("s5_rst_busy", int'(busy), 0);
      check("s5_rst_rd_valid", int'(rd_valid), 0);
      check("s5_rst_rd_data", int'(rd_data), 0);
      check("s5_rst_overflow", int'(overflow), 0);
      check("s5_rst_wr_count", int'(wr_count), 0);
      check("s5_rst_clip_count", int'(clip_count), 0);
      step();
      resetn = 1'b1;
      step();
      check("s5_idle_busy", int'(busy), 0);
      plot(8'd20, 7'd20, 3'd5);
      drain();
      check("s5_wr_count_post", int'(wr_count), 1);
      read(8'd20, 7'd20, 3'd5);
      read(8'd0, 7'd0, 3'd6);
      read(8'd10, 7'd10, 3'd6);
      read(8'd80, 7'd60, 3'd2);
      step();
      step();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
